// File: rtl/vga_sprite_layer.sv
// vga_sprite_layer
//   Multi-sprite draw stage for the VGA pixel pipeline. Each of SPRITES
//   sprites reads its own ROM. Sprite 0 has the highest priority, and
//   pixels equal to KEY_RGB are transparent. Sprite positions and enables
//   are sampled once per frame, on the rising edge of vblnk_in, so a sprite
//   never tears partway through a frame. Collisions between opaque sprite
//   pixels are gathered over a frame and reported when the delayed vblank
//   rises. All timing signals pass through with a latency of two clocks.
//
// Ports
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   hcount_in/vcount_in   pixel coordinates (11 bit)
//   hsync_in/vsync_in     sync timing
//   hblnk_in/vblnk_in     blanking timing
//   rgb_in                background pixel (12 bit)
//   x_pos/y_pos           per-sprite top-left position, 12 bits per sprite
//   sprite_en             per-sprite enable
//   pixel_addr            per-sprite ROM address, ADDR_W bits per sprite
//   rgb_pixel             per-sprite ROM data, valid one clock after address
//   *_out                 timing and pixel outputs delayed by two clocks
//   collision_mask        sprites that collided in the last completed frame
//   frame_tick            one-clock pulse when collision_mask updates
module vga_sprite_layer #(
  parameter int          SPRITES = 2,
  parameter int          SPR_W   = 48,
  parameter int          SPR_H   = 64,
  parameter int          ADDR_W  = 12,
  parameter logic [11:0] KEY_RGB = 12'h0F0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [10:0]                 hcount_in,
  input  logic [10:0]                 vcount_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        hblnk_in,
  input  logic                        vblnk_in,
  input  logic [11:0]                 rgb_in,
  input  logic [SPRITES*12-1:0]       x_pos,
  input  logic [SPRITES*12-1:0]       y_pos,
  input  logic [SPRITES-1:0]          sprite_en,
  output logic [SPRITES*ADDR_W-1:0]   pixel_addr,
  input  logic [SPRITES*12-1:0]       rgb_pixel,
  output logic [10:0]                 hcount_out,
  output logic [10:0]                 vcount_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic [11:0]                 rgb_out,
  output logic [SPRITES-1:0]          collision_mask,
  output logic                        frame_tick
);

  logic [SPRITES*12-1:0]     x_sh;
  logic [SPRITES*12-1:0]     y_sh;
  logic [SPRITES-1:0]        en_sh;

  logic [10:0]               hcount_d1;
  logic [10:0]               vcount_d1;
  logic                      hsync_d1;
  logic                      vsync_d1;
  logic                      hblnk_d1;
  logic                      vblnk_d1;
  logic [11:0]               rgb_d1;
  logic [SPRITES-1:0]        hit_d1;

  logic [12:0]               h13;
  logic [12:0]               v13;
  logic [12:0]               x13;
  logic [12:0]               y13;
  logic [SPRITES-1:0]        hit_c;
  logic [SPRITES*ADDR_W-1:0] addr_c;

  logic [SPRITES-1:0]        opaque_c;
  logic [SPRITES-1:0]        coll_c;
  logic [SPRITES-1:0]        acc;
  logic [11:0]               rgb_c;
  logic                      latch_rise;
  logic                      frame_rise;

  // vblnk_d1 holds the previous vblnk_in, and vblnk_out holds the previous
  // stage-2 vblank. Comparing against them gives the two rising edges.
  assign latch_rise = vblnk_in & ~vblnk_d1;
  assign frame_rise = vblnk_d1 & ~vblnk_out;

  // Compare in 13 bits so that x+SPR_W near 4095 cannot wrap. A sprite that
  // hangs off the right or bottom edge is clipped, not wrapped around.
  assign h13 = {2'b00, hcount_in};
  assign v13 = {2'b00, vcount_in};

  always_comb begin
    hit_c  = '0;
    addr_c = '0;
    x13    = '0;
    y13    = '0;
    for (int i = 0; i < SPRITES; i++) begin
      x13 = {1'b0, x_sh[12*i +: 12]};
      y13 = {1'b0, y_sh[12*i +: 12]};
      if (en_sh[i] && !hblnk_in && !vblnk_in &&
          (h13 >= x13) && (h13 < x13 + 13'(SPR_W)) &&
          (v13 >= y13) && (v13 < y13 + 13'(SPR_H))) begin
        hit_c[i] = 1'b1;
        addr_c[ADDR_W*i +: ADDR_W] =
          ADDR_W'(32'(v13 - y13) * 32'(SPR_W) + 32'(h13 - x13));
      end
    end
  end

  // The shadow registers load only on the vblank rise. The stage-1 compare
  // then sees a position set that stays fixed for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_sh  <= '0;
      y_sh  <= '0;
      en_sh <= '0;
    end else if (latch_rise) begin
      x_sh  <= x_pos;
      y_sh  <= y_pos;
      en_sh <= sprite_en;
    end
  end

  // Stage 1: delay the timing signals and issue the ROM addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_d1  <= '0;
      vcount_d1  <= '0;
      hsync_d1   <= 1'b0;
      vsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      rgb_d1     <= '0;
      hit_d1     <= '0;
      pixel_addr <= '0;
    end else begin
      hcount_d1  <= hcount_in;
      vcount_d1  <= vcount_in;
      hsync_d1   <= hsync_in;
      vsync_d1   <= vsync_in;
      hblnk_d1   <= hblnk_in;
      vblnk_d1   <= vblnk_in;
      rgb_d1     <= rgb_in;
      hit_d1     <= hit_c;
      pixel_addr <= addr_c;
    end
  end

  // The loop runs from the lowest priority up, so the lowest-index opaque
  // sprite is assigned last and wins. A collision is recorded only when
  // more than one opaque bit is set (x & (x-1) is non-zero).
  always_comb begin
    opaque_c = '0;
    rgb_c    = rgb_d1;
    for (int i = SPRITES - 1; i >= 0; i--) begin
      opaque_c[i] = hit_d1[i] && (rgb_pixel[12*i +: 12] != KEY_RGB);
      if (opaque_c[i]) begin
        rgb_c = rgb_pixel[12*i +: 12];
      end
    end
    if (hblnk_d1 || vblnk_d1) begin
      rgb_c = 12'h000;
    end
    coll_c = ((opaque_c & (opaque_c - SPRITES'(1))) != '0) ? opaque_c : '0;
  end

  // Stage 2: register the outputs. On the delayed vblank rise, report the
  // accumulator, including any collision from the same cycle, and restart
  // accumulation from that cycle's collision bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out     <= '0;
      vcount_out     <= '0;
      hsync_out      <= 1'b0;
      vsync_out      <= 1'b0;
      hblnk_out      <= 1'b0;
      vblnk_out      <= 1'b0;
      rgb_out        <= '0;
      acc            <= '0;
      collision_mask <= '0;
      frame_tick     <= 1'b0;
    end else begin
      hcount_out <= hcount_d1;
      vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;
      vblnk_out  <= vblnk_d1;
      rgb_out    <= rgb_c;
      if (frame_rise) begin
        collision_mask <= acc | coll_c;
        frame_tick     <= 1'b1;
        acc            <= coll_c;
      end else begin
        frame_tick     <= 1'b0;
        acc            <= acc | coll_c;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_layer.sv
// tb_vga_sprite_layer
//   Directed bench for vga_sprite_layer with two sprites of 48x64 pixels.
//   Each driven pixel pushes its expected outputs onto a scoreboard queue.
//   The entry is popped and compared two clocks later, and the ROM address
//   is compared one clock later. The bench also acts as a ROM that returns
//   a single programmable colour for each sprite.
module tb_vga_sprite_layer;

  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [10:0] vcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [23:0] x_pos = '0;
  logic [23:0] y_pos = '0;
  logic [1:0]  sprite_en = '0;
  logic [23:0] pixel_addr;
  logic [23:0] rgb_pixel;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic [1:0]  collision_mask;
  logic        frame_tick;

  logic [11:0] rom_c [2];

  typedef struct packed {
    logic [11:0] rgb;
    logic [25:0] timing;
    logic [1:0]  mask;
    logic        tick;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] addr_q[$];

  int          errors = 0;
  int          checks = 0;

  int          m_x [2];
  int          m_y [2];
  logic [1:0]  m_en;
  logic [1:0]  m_acc;
  logic [1:0]  m_mask;
  logic        m_prev_vb;

  assign rgb_pixel = {rom_c[1], rom_c[0]};

  vga_sprite_layer #(
    .SPRITES(2), .SPR_W(48), .SPR_H(64), .ADDR_W(12), .KEY_RGB(KEY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .sprite_en(sprite_en),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .collision_mask(collision_mask),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_en      = '0;
    m_acc     = '0;
    m_mask    = '0;
    m_prev_vb = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rgb"}, 32'(rgb_out), 32'd0);
    checkOutput({tag, " timing"},
                32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                32'd0);
    checkOutput({tag, " addr"}, 32'(pixel_addr), 32'd0);
    checkOutput({tag, " mask/tick"}, 32'({collision_mask, frame_tick}), 32'd0);
  endtask

  // Drives one pixel at the falling edge after comparing the outputs that
  // are due. It then predicts the outputs for this pixel from the
  // frame-latched sprite state and pushes them onto the scoreboard.
  task automatic applyStimulus(input int h, input int v, input logic hb, input logic vb);
    exp_t        e;
    logic [23:0] a;
    logic [1:0]  hit;
    logic [1:0]  opq;
    logic [1:0]  coll;
    logic [11:0] er;
    logic        rise;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checkOutput("rgb_out", 32'(rgb_out), 32'(e.rgb));
      checkOutput("timing_out",
                  32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                  32'(e.timing));
      checkOutput("collision_mask", 32'(collision_mask), 32'(e.mask));
      checkOutput("frame_tick", 32'(frame_tick), 32'(e.tick));
    end
    if (addr_q.size() >= 1) begin
      a = addr_q.pop_front();
      checkOutput("pixel_addr", 32'(pixel_addr), 32'(a));
    end
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = (h % 2) == 1;
    vsync_in  = (v % 2) == 1;
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = 12'(h) ^ 12'h555;

    a = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i] = m_en[i] && !hb && !vb && (h >= m_x[i]) && (h < m_x[i] + 48) &&
               (v >= m_y[i]) && (v < m_y[i] + 64);
      if (hit[i]) a[12*i +: 12] = 12'((v - m_y[i]) * 48 + (h - m_x[i]));
      opq[i] = hit[i] && (rom_c[i] != KEY);
    end
    er = rgb_in;
    if (opq[1]) er = rom_c[1];
    if (opq[0]) er = rom_c[0];
    if (hb || vb) er = 12'h000;
    coll = (opq == 2'b11) ? 2'b11 : 2'b00;
    rise = vb && !m_prev_vb;
    if (rise) begin
      m_mask = m_acc | coll;
      m_acc  = coll;
      for (int i = 0; i < 2; i++) begin
        m_x[i] = int'(x_pos[12*i +: 12]);
        m_y[i] = int'(y_pos[12*i +: 12]);
      end
      m_en = sprite_en;
    end else begin
      m_acc = m_acc | coll;
    end
    m_prev_vb = vb;
    e.rgb    = er;
    e.timing = {11'(h), 11'(v), hsync_in, vsync_in, hb, vb};
    e.mask   = m_mask;
    e.tick   = rise;
    exp_q.push_back(e);
    addr_q.push_back(a);
  endtask

  task automatic scanLine(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) applyStimulus(h, v, 1'b0, 1'b0);
  endtask

  // One unblanked, hblank-only step, then three vblank steps. The first
  // vblank step is the rising edge that latches positions and reports.
  task automatic frameGap();
    applyStimulus(700, 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 500, 1'b1, 1'b1);
  endtask

  initial begin
    rom_c[0] = 12'hABC;
    rom_c[1] = 12'hDEF;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    // Single sprite at (100,50).
    x_pos = {12'd0, 12'd100};
    y_pos = {12'd0, 12'd50};
    sprite_en = 2'b01;
    frameGap();
    scanLine(49, 96, 150);
    scanLine(50, 96, 150);
    scanLine(51, 98, 100);
    applyStimulus(101, 51, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("addr(101,51)", 32'(pixel_addr[11:0]), 32'd49);
    scanLine(51, 102, 104);
    scanLine(113, 96, 150);
    scanLine(114, 96, 104);
    applyStimulus(120, 60, 1'b1, 1'b0);

    // Two opaque sprites overlapping at (200,200).
    x_pos = {12'd200, 12'd200};
    y_pos = {12'd200, 12'd200};
    sprite_en = 2'b11;
    frameGap();
    scanLine(200, 196, 250);
    scanLine(263, 196, 250);
    x_pos = {12'd400, 12'd200};
    frameGap();
    checkOutput("overlap mask", 32'(collision_mask), 32'd3);
    scanLine(200, 196, 250);
    scanLine(200, 396, 450);
    frameGap();
    checkOutput("no-overlap mask", 32'(collision_mask), 32'd0);

    // A transparent pixel in sprite 0 shows sprite 1 through it.
    x_pos = {12'd200, 12'd200};
    rom_c[0] = KEY;
    frameGap();
    scanLine(210, 196, 250);
    frameGap();
    checkOutput("transparent mask", 32'(collision_mask), 32'd0);

    // A mid-frame position change waits for the next vblank rise.
    rom_c[0] = 12'hABC;
    x_pos = {12'd0, 12'd100};
    y_pos = {12'd0, 12'd50};
    sprite_en = 2'b01;
    frameGap();
    scanLine(60, 96, 150);
    x_pos = {12'd0, 12'd300};
    scanLine(61, 96, 150);
    scanLine(61, 296, 350);
    frameGap();
    scanLine(60, 96, 150);
    scanLine(60, 296, 350);

    // Right-edge clipping with no wrap to the next line.
    x_pos = {12'd0, 12'd620};
    y_pos = {12'd0, 12'd10};
    frameGap();
    scanLine(10, 600, 639);
    for (int h = 640; h <= 650; h++) applyStimulus(h, 10, 1'b1, 1'b0);
    scanLine(11, 0, 30);
    scanLine(11, 610, 639);

    // Reset during active video with a collision pending.
    x_pos = {12'd200, 12'd200};
    y_pos = {12'd200, 12'd200};
    sprite_en = 2'b11;
    frameGap();
    scanLine(200, 198, 205);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("mid-frame reset");
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    x_pos = {12'd400, 12'd200};
    frameGap();
    scanLine(200, 198, 205);
    frameGap();
    checkOutput("post-reset mask", 32'(collision_mask), 32'd0);
    applyStimulus(0, 500, 1'b1, 1'b1);
    applyStimulus(0, 500, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sprite_layer.md
Name: vga_sprite_layer

Overview:
Parametrised multi-sprite draw stage for the VGA pixel pipeline. It generalises the single ROM-backed rectangle stage into SPRITES independent sprites, each with its own ROM port. Sprites are drawn by fixed priority with colour-key transparency. Positions and enables are latched once per frame so sprites never tear mid-frame. Per-frame sprite-to-sprite collisions are reported for game logic. It sits between the obstacle stage and the mouse overlay and passes all timing signals through with matched latency.

Parameters:
SPRITES, 2, number of sprites (1..8); index 0 has highest priority.
SPR_W, 48, sprite width in pixels.
SPR_H, 64, sprite height in pixels.
ADDR_W, 12, per-sprite ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
KEY_RGB, 12'h0F0, transparent colour key.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hcount_in, vcount_in  in  11 each  pixel coordinates
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
rgb_in  in  12  background pixel
x_pos  in  SPRITES*12  per-sprite top-left x; sprite i occupies bits [12i+11:12i]
y_pos  in  SPRITES*12  per-sprite top-left y, same packing
sprite_en  in  SPRITES  per-sprite enable
pixel_addr  out  SPRITES*ADDR_W  per-sprite ROM address
rgb_pixel  in  SPRITES*12  per-sprite ROM data, valid 1 clk after address
hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  as inputs  delayed outputs
collision_mask  out  SPRITES  sprites that collided in the last completed frame
frame_tick  out  1  one-clk pulse when collision_mask updates

Behaviour:
- Reset (async, rst_n=0): all outputs 0; latched x, y and enable registers 0; collision accumulator 0; pipeline registers 0.
- Frame latch: on the input cycle where vblnk_in goes 0->1, copy x_pos, y_pos and sprite_en into shadow registers. Drawing uses only shadow values. Changes outside this cycle have no effect until the next vblnk rise.
- Stage 1 (registered):
  - hit_i = en_i & !hblnk_in & !vblnk_in & hcount_in in [x_i, x_i+SPR_W-1] & vcount_in in [y_i, y_i+SPR_H-1].
  - Compare in 13 bits; x_i+SPR_W does not wrap. A sprite partly past the right or bottom edge is clipped; no wrap to the opposite side.
  - pixel_addr_i = (vcount_in-y_i)*SPR_W + (hcount_in-x_i), truncated to ADDR_W.
  - When hit_i=0, pixel_addr_i = 0.
- Stage 2 (registered, ROM data arrives):
  - opaque_i = hit_i(delayed) & (rgb_pixel_i != KEY_RGB).
  - rgb_out = rgb_pixel of the lowest i with opaque_i; otherwise rgb_in delayed.
  - During blanking, rgb_out = 12'h000.
- Latency: exactly 2 clk from every *_in to the matching *_out, including hsync/vsync/hblnk/vblnk/counts.
- Collision: on any stage-2 cycle with two or more opaque_i set, OR those bits into the accumulator.
- Frame report: when the stage-2 vblnk goes 0->1:
  - collision_mask <= accumulator, including any collision from that same cycle.
  - frame_tick = 1 for that single clk.
  - Accumulator clears to 0, or to the same-cycle collision bits if any.
- Overlapping sprites where the higher-priority pixel is transparent: the lower sprite shows through, and no collision is counted unless both are opaque.
- Reset mid-frame: everything returns to reset values immediately. The first frame_tick after reset reports only collisions seen since reset.
- SPRITES=1: collision_mask is always 0; frame_tick still pulses.

Test Plan:
- Single sprite 0 at (100,50), ROM returns 12'hABC -> rgb_out=ABC for hcount 100..147, vcount 50..113, exactly 2 clk after input; background elsewhere; pixel_addr at (101,51) = 49.
- Sprites 0 and 1 both at (200,200), both opaque -> rgb_out is sprite 0 data; at next vblnk rise frame_tick pulses with collision_mask=2'b11; next frame with no overlap -> collision_mask=2'b00.
- Sprite 0 returns KEY_RGB over sprite 1 -> sprite 1 pixel shown; collision_mask=2'b00.
- Change x_pos mid-frame from 100 to 300 -> current frame still draws at 100; from the frame after the vblnk rise, draws at 300.
- Sprite at x=620, SPR_W=48, 640-wide active area -> pixels 620..639 drawn; nothing at hcount 0..27 of the same or next line.
- Assert rst_n=0 during active video with collision pending -> all outputs 0 immediately; after release the next frame_tick reports mask 0 if no new overlap.
